// File: rtl/hyperbus_read_packer.sv
// -----------------------------------------------------------------------------
// hyperbus_read_packer
//   Packs 16-bit words popped from the HyperBus read CDC FIFO (clk0 domain) into
//   32-bit read beats with byte strobes and a last flag. It tracks the remaining
//   word count of the current burst and flags a timeout when the FIFO delivers
//   no word for TIMEOUT_CYCLES consecutive receive cycles.
//
// Ports
//   clk0         system clock
//   rst_i        synchronous active-high reset
//   start_i      begin a burst (honoured in IDLE only, ignored when len_i == 0)
//   len_i        burst length in 16-bit words, sampled with start_i
//   start_odd_i  first word lands in the upper half-word
//   abort_i      cancel the current burst, drop any pending beat
//   in_valid_i   FIFO word valid
//   in_data_i    FIFO word
//   in_ready_o   FIFO pop
//   out_valid_o  beat valid
//   out_data_o   beat data
//   out_strb_o   byte strobes
//   out_last_o   final beat of the burst
//   out_ready_i  downstream accepts beat
//   busy_o       FSM not in IDLE
//   error_o      sticky timeout flag, cleared by the next accepted start
// -----------------------------------------------------------------------------
module hyperbus_read_packer #(
  parameter int LEN_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk0,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             start_odd_i,
  input  logic             abort_i,
  input  logic             in_valid_i,
  input  logic [15:0]      in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [31:0]      out_data_o,
  output logic [3:0]       out_strb_o,
  output logic             out_last_o,
  input  logic             out_ready_i,
  output logic             busy_o,
  output logic             error_o
);

  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_LAST = 2'd2
  } state_e;

  state_e              state_q;
  logic [LEN_W-1:0]    rem_q;
  logic                half_q;     // next word goes to the upper half-word
  logic                low_vld_q;  // low holding register carries a word
  logic [15:0]         low_q;
  logic [TCNT_W-1:0]   tcnt_q;
  logic                out_valid_q;
  logic [31:0]         out_data_q;
  logic [3:0]          out_strb_q;
  logic                out_last_q;
  logic                error_q;

  logic                in_ready_s;
  logic                accept_s;
  logic                final_s;
  logic                beat_s;
  logic                out_pop_s;
  logic                tcnt_hit_s;
  logic [31:0]         beat_data_s;
  logic [3:0]          beat_strb_s;

  // Handshake decode and assembly of the beat formed by the word being accepted
  always_comb begin
    in_ready_s  = (state_q == S_RECV) && (!out_valid_q || out_ready_i);
    accept_s    = in_valid_i && in_ready_s;
    final_s     = (rem_q == LEN_W'(1));
    beat_s      = accept_s && (half_q || final_s);
    out_pop_s   = out_valid_q && out_ready_i;
    tcnt_hit_s  = (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1));
    beat_data_s = 32'h0000_0000;
    beat_strb_s = 4'h0;
    if (half_q) begin
      if (low_vld_q) begin
        beat_data_s = {in_data_i, low_q};
        beat_strb_s = 4'hF;
      end else begin
        // odd start: nothing was received for the lower half
        beat_data_s = {in_data_i, 16'h0000};
        beat_strb_s = 4'hC;
      end
    end else begin
      // only reached as a beat when this is the burst's final word
      beat_data_s = {16'h0000, in_data_i};
      beat_strb_s = 4'h3;
    end
  end

  // Burst FSM with registered beat outputs, timeout counter and error flag
  always_ff @(posedge clk0) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      rem_q       <= {LEN_W{1'b0}};
      half_q      <= 1'b0;
      low_vld_q   <= 1'b0;
      low_q       <= 16'h0000;
      tcnt_q      <= {TCNT_W{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= 32'h0000_0000;
      out_strb_q  <= 4'h0;
      out_last_q  <= 1'b0;
      error_q     <= 1'b0;
    end else if (abort_i) begin
      state_q     <= S_IDLE;
      rem_q       <= {LEN_W{1'b0}};
      half_q      <= 1'b0;
      low_vld_q   <= 1'b0;
      tcnt_q      <= {TCNT_W{1'b0}};
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // a non-final beat left behind by a timeout drains here
          if (out_pop_s) begin
            out_valid_q <= 1'b0;
          end
          if (start_i && (len_i != {LEN_W{1'b0}})) begin
            state_q   <= S_RECV;
            rem_q     <= len_i;
            half_q    <= start_odd_i;
            low_vld_q <= 1'b0;
            tcnt_q    <= {TCNT_W{1'b0}};
            error_q   <= 1'b0;
          end
        end
        S_RECV: begin
          if (accept_s) begin
            rem_q  <= rem_q - LEN_W'(1);
            tcnt_q <= {TCNT_W{1'b0}};
            if (beat_s) begin
              // in_ready guarantees the output register is free or draining now
              out_valid_q <= 1'b1;
              out_data_q  <= beat_data_s;
              out_strb_q  <= beat_strb_s;
              out_last_q  <= final_s;
              half_q      <= 1'b0;
              low_vld_q   <= 1'b0;
              if (final_s) begin
                state_q <= S_LAST;
              end
            end else begin
              low_q     <= in_data_i;
              low_vld_q <= 1'b1;
              half_q    <= 1'b1;
              if (out_pop_s) begin
                out_valid_q <= 1'b0;
              end
            end
          end else begin
            if (out_pop_s) begin
              out_valid_q <= 1'b0;
            end
            if (tcnt_hit_s) begin
              error_q   <= 1'b1;
              state_q   <= S_IDLE;
              half_q    <= 1'b0;
              low_vld_q <= 1'b0;
              tcnt_q    <= {TCNT_W{1'b0}};
            end else begin
              tcnt_q <= tcnt_q + TCNT_W'(1);
            end
          end
        end
        S_LAST: begin
          if (out_pop_s) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_s;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_strb_o  = out_strb_q;
  assign out_last_o  = out_last_q;
  assign busy_o      = (state_q != S_IDLE);
  assign error_o     = error_q;

endmodule

// File: tb/tb_hyperbus_read_packer.sv
// -----------------------------------------------------------------------------
// tb_hyperbus_read_packer
//   Table-driven bursts with a beat scoreboard, plus hand-written sequences for
//   timeout, abort and mid-burst reset.
// -----------------------------------------------------------------------------
module tb_hyperbus_read_packer;

  localparam int LEN_W = 16;
  localparam int TO    = 40;

  logic             clk0 = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic [LEN_W-1:0] len_i;
  logic             start_odd_i;
  logic             abort_i;
  logic             in_valid_i;
  logic [15:0]      in_data_i;
  logic             in_ready_o;
  logic             out_valid_o;
  logic [31:0]      out_data_o;
  logic [3:0]       out_strb_o;
  logic             out_last_o;
  logic             out_ready_i;
  logic             busy_o;
  logic             error_o;

  always #5 clk0 = ~clk0;

  hyperbus_read_packer #(.LEN_W(LEN_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk0(clk0), .rst_i(rst_i), .start_i(start_i), .len_i(len_i),
    .start_odd_i(start_odd_i), .abort_i(abort_i), .in_valid_i(in_valid_i),
    .in_data_i(in_data_i), .in_ready_o(in_ready_o), .out_valid_o(out_valid_o),
    .out_data_o(out_data_o), .out_strb_o(out_strb_o), .out_last_o(out_last_o),
    .out_ready_i(out_ready_i), .busy_o(busy_o), .error_o(error_o)
  );

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } beat_t;

  beat_t sb_q[$];

  typedef struct {
    int              len;
    bit              odd;
    logic [15:0]     base;
    logic [15:0]     step;
    bit              stall;
    int              nb;
    logic [3:0][31:0] d;
    logic [3:0][3:0]  s;
  } vec_t;

  vec_t tbl[8];

  // Scoreboard monitor: compare held and handshaken beats against the queue
  always @(negedge clk0) begin
    if (!rst_i && out_valid_o) begin
      if (!out_ready_i) begin
        check("in_ready_while_held", in_ready_o, 32'd0);
      end
      if (sb_q.size() == 0) begin
        if (out_ready_i) begin
          checks++;
          fails++;
          $display("FAIL unexpected_beat: got data 0x%08h strb %h, none expected", out_data_o, out_strb_o);
        end
      end else begin
        check("beat_data", out_data_o, sb_q[0].data);
        check("beat_strb", {28'd0, out_strb_o}, {28'd0, sb_q[0].strb});
        check("beat_last", {31'd0, out_last_o}, {31'd0, sb_q[0].last});
        if (out_ready_i) begin
          void'(sb_q.pop_front());
        end
      end
    end
  end

  task automatic set_vec(input int i, input int len, input bit odd, input logic [15:0] base,
                         input logic [15:0] step, input bit stall, input int nb,
                         input logic [31:0] d0, input logic [3:0] s0,
                         input logic [31:0] d1, input logic [3:0] s1,
                         input logic [31:0] d2, input logic [3:0] s2);
    tbl[i].len = len;  tbl[i].odd = odd;  tbl[i].base = base;  tbl[i].step = step;
    tbl[i].stall = stall;  tbl[i].nb = nb;
    tbl[i].d[0] = d0;  tbl[i].s[0] = s0;
    tbl[i].d[1] = d1;  tbl[i].s[1] = s1;
    tbl[i].d[2] = d2;  tbl[i].s[2] = s2;
    tbl[i].d[3] = 32'd0;  tbl[i].s[3] = 4'h0;
  endtask

  // Hold in_valid_i until the word is popped (bounded)
  task automatic wait_accept(input string name);
    bit acc = 1'b0;
    int n = 0;
    while (!acc && n < 50) begin
      @(negedge clk0);
      acc = in_ready_o;
      @(posedge clk0);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      fails++;
      $display("FAIL %s: word not accepted within 50 cycles", name);
    end
  endtask

  task automatic pulse_start(input int len, input bit odd);
    start_i = 1'b1;
    len_i = LEN_W'(len);
    start_odd_i = odd;
    @(posedge clk0);
    #1;
    start_i = 1'b0;
  endtask

  task automatic drive_burst(input vec_t v);
    beat_t b;
    int n;
    for (int k = 0; k < v.nb; k++) begin
      b.data = v.d[k];
      b.strb = v.s[k];
      b.last = (k == v.nb - 1);
      sb_q.push_back(b);
    end
    pulse_start(v.len, v.odd);
    check("busy_after_start", {31'd0, busy_o}, 32'd1);
    check("error_after_start", {31'd0, error_o}, 32'd0);
    for (int w = 0; w < v.len; w++) begin
      in_valid_i = 1'b1;
      in_data_i = 16'(v.base + v.step * 16'(w));
      wait_accept("word_accept");
    end
    in_valid_i = 1'b0;
    n = 0;
    while ((busy_o || sb_q.size() != 0) && n < 50) begin
      @(posedge clk0);
      #1;
      n++;
    end
    check("busy_after_burst", {31'd0, busy_o}, 32'd0);
    check("beats_outstanding", 32'(sb_q.size()), 32'd0);
    check("valid_after_burst", {31'd0, out_valid_o}, 32'd0);
    sb_q.delete();
  endtask

  task automatic stall_output();
    int n = 0;
    while (!out_valid_o && n < 50) begin
      @(posedge clk0);
      #1;
      n++;
    end
    out_ready_i = 1'b0;
    repeat (5) @(posedge clk0);
    #1;
    out_ready_i = 1'b1;
  endtask

  initial begin
    beat_t b;
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t b;
    rst_i = 1'b1;  start_i = 1'b0;  len_i = '0;  start_odd_i = 1'b0;  abort_i = 1'b0;
    in_valid_i = 1'b0;  in_data_i = 16'h0000;  out_ready_i = 1'b1;
    repeat (3) @(posedge clk0);
    #1;
    check("rst_in_ready", {31'd0, in_ready_o}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    check("rst_out_data", out_data_o, 32'd0);
    check("rst_out_strb", {28'd0, out_strb_o}, 32'd0);
    check("rst_out_last", {31'd0, out_last_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_error", {31'd0, error_o}, 32'd0);
    rst_i = 1'b0;

    // len 0 start is ignored
    pulse_start(0, 1'b0);
    check("len0_ignored", {31'd0, busy_o}, 32'd0);

    set_vec(0, 4, 1'b0, 16'h1111, 16'h1111, 1'b0, 2, 32'h2222_1111, 4'hF, 32'h4444_3333, 4'hF, 32'd0, 4'h0);
    set_vec(1, 3, 1'b0, 16'hAAAA, 16'h1111, 1'b0, 2, 32'hBBBB_AAAA, 4'hF, 32'h0000_CCCC, 4'h3, 32'd0, 4'h0);
    set_vec(2, 3, 1'b1, 16'hAAAA, 16'h1111, 1'b0, 2, 32'hAAAA_0000, 4'hC, 32'hCCCC_BBBB, 4'hF, 32'd0, 4'h0);
    set_vec(3, 1, 1'b0, 16'h5A5A, 16'h0000, 1'b0, 1, 32'h0000_5A5A, 4'h3, 32'd0, 4'h0, 32'd0, 4'h0);
    set_vec(4, 1, 1'b1, 16'h1234, 16'h0000, 1'b0, 1, 32'h1234_0000, 4'hC, 32'd0, 4'h0, 32'd0, 4'h0);
    set_vec(5, 2, 1'b1, 16'h0F00, 16'h0001, 1'b0, 2, 32'h0F00_0000, 4'hC, 32'h0000_0F01, 4'h3, 32'd0, 4'h0);
    set_vec(6, 6, 1'b0, 16'h0001, 16'h0001, 1'b1, 3, 32'h0002_0001, 4'hF, 32'h0004_0003, 4'hF, 32'h0006_0005, 4'hF);
    set_vec(7, 5, 1'b1, 16'hA001, 16'h0001, 1'b0, 3, 32'hA001_0000, 4'hC, 32'hA003_A002, 4'hF, 32'hA005_A004, 4'hF);

    for (int i = 0; i < 8; i++) begin
      fork
        drive_burst(tbl[i]);
        if (tbl[i].stall) stall_output();
      join
    end

    // Timeout: one word of four, then silence
    pulse_start(4, 1'b0);
    in_valid_i = 1'b1;
    in_data_i = 16'h7777;
    wait_accept("to_first_word");
    in_valid_i = 1'b0;
    repeat (TO - 1) @(posedge clk0);
    #1;
    check("to_error_early", {31'd0, error_o}, 32'd0);
    check("to_busy_early", {31'd0, busy_o}, 32'd1);
    @(posedge clk0);
    #1;
    check("to_error", {31'd0, error_o}, 32'd1);
    check("to_busy", {31'd0, busy_o}, 32'd0);
    check("to_no_beat", {31'd0, out_valid_o}, 32'd0);
    repeat (3) @(posedge clk0);
    #1;
    check("to_error_sticky", {31'd0, error_o}, 32'd1);
    drive_burst(tbl[3]);

    // Abort with a beat pending; start in the same cycle is ignored
    out_ready_i = 1'b0;
    b.data = 32'hB002_B001;  b.strb = 4'hF;  b.last = 1'b0;
    sb_q.push_back(b);
    pulse_start(8, 1'b0);
    in_valid_i = 1'b1;
    in_data_i = 16'hB001;
    wait_accept("abort_w0");
    in_data_i = 16'hB002;
    wait_accept("abort_w1");
    in_valid_i = 1'b0;
    check("abort_beat_pending", {31'd0, out_valid_o}, 32'd1);
    abort_i = 1'b1;
    start_i = 1'b1;
    len_i = LEN_W'(4);
    @(posedge clk0);
    #1;
    abort_i = 1'b0;
    start_i = 1'b0;
    sb_q.delete();
    check("abort_valid", {31'd0, out_valid_o}, 32'd0);
    check("abort_busy", {31'd0, busy_o}, 32'd0);
    check("abort_error_kept", {31'd0, error_o}, 32'd0);
    out_ready_i = 1'b1;
    @(posedge clk0);
    #1;
    check("abort_start_ignored", {31'd0, busy_o}, 32'd0);

    // Mid-burst reset
    pulse_start(4, 1'b1);
    in_valid_i = 1'b1;
    in_data_i = 16'hC001;
    wait_accept("rst_w0");
    in_valid_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk0);
    #1;
    rst_i = 1'b0;
    sb_q.delete();
    check("midrst_busy", {31'd0, busy_o}, 32'd0);
    check("midrst_valid", {31'd0, out_valid_o}, 32'd0);
    check("midrst_data", out_data_o, 32'd0);
    drive_burst(tbl[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
